// File: rtl/slot_pwr_sequencer.sv
// slot_pwr_sequencer: staggered round-robin slot power-up for the PDB CPLD.
// Define SLOT_PG_CHECK_EN to add per-slot power-good supervision with sticky faults.
module slot_pwr_sequencer #(
    parameter int NUM_SLOTS  = 4,
    parameter int STAGGER_MS = 100
) (
    input  logic                 clk_1k,
    input  logic                 cpld_rst_n,
    input  logic [NUM_SLOTS-1:0] prsnt_db,
    input  logic                 sys_pwr_ok,
    input  logic [NUM_SLOTS-1:0] slot_pg,
    input  logic                 fault_clr,
    output logic [NUM_SLOTS-1:0] slot_pwr_en,
    output logic [NUM_SLOTS-1:0] slot_fault,
    output logic                 seq_busy
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = (STAGGER_MS > 1) ? $clog2(STAGGER_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER_MS - 1);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_SLOTS - 1);

    typedef enum logic {
        IDLE,
        STAGGER
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     cur;
    logic [NUM_SLOTS-1:0] req;
    logic [NUM_SLOTS-1:0] en_nxt;
    logic [NUM_SLOTS-1:0] fault_nxt;
    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic                 stagger_done;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_SLOTS) begin
            sum = sum - NUM_SLOTS;
        end
        return IDX_W'(sum);
    endfunction

    assign req          = prsnt_db & ~slot_pwr_en & ~slot_fault & {NUM_SLOTS{sys_pwr_ok}};
    assign stagger_done = (state == STAGGER) && (cnt == CNT_LAST);

    // Round-robin search starts just past the last granted slot so every slot gets a turn.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            if (!grant_vld && req[wrap_idx(rr_ptr, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_idx(rr_ptr, k);
            end
        end
    end

    always_comb begin
        en_nxt    = slot_pwr_en;
        fault_nxt = slot_fault;
`ifdef SLOT_PG_CHECK_EN
        if (fault_clr) begin
            fault_nxt = '0;
        end
        // The slot still ramping inside its window is only judged at the window's last edge.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_pwr_en[i] && !slot_pg[i] &&
                !((state == STAGGER) && (IDX_W'(i) == cur) && !stagger_done)) begin
                en_nxt[i]    = 1'b0;
                fault_nxt[i] = 1'b1;
            end
        end
`else
        fault_nxt = '0;
`endif
        if ((state == IDLE) && grant_vld) begin
            en_nxt[grant_idx] = 1'b1;
        end
        en_nxt    = en_nxt & prsnt_db;
        fault_nxt = fault_nxt & prsnt_db;
    end

`ifndef SLOT_PG_CHECK_EN
    logic unused_pg;
    assign unused_pg = ^{slot_pg, fault_clr, cur};
`endif

    // Rail loss drops every enable but keeps faults and the arbiter position.
    always_ff @(posedge clk_1k) begin
        if (!cpld_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= PTR_INIT;
            cur         <= '0;
            slot_pwr_en <= '0;
            slot_fault  <= '0;
            seq_busy    <= 1'b0;
        end else if (!sys_pwr_ok) begin
            state       <= IDLE;
            cnt         <= '0;
            slot_pwr_en <= '0;
            seq_busy    <= 1'b0;
        end else begin
            slot_pwr_en <= en_nxt;
            slot_fault  <= fault_nxt;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state    <= STAGGER;
                        cnt      <= '0;
                        rr_ptr   <= grant_idx;
                        cur      <= grant_idx;
                        seq_busy <= 1'b1;
                    end
                end
                STAGGER: begin
                    if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        seq_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    seq_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/slot_pwr_sequencer.md
# slot_pwr_sequencer

Sequences per-slot power enables on the PDB CPLD from debounced slot-presence inputs. Sits downstream of the per-slot presence debouncers. Shares one staggered power-up window among all present slots with a round-robin arbiter, so only one slot inrush occurs at a time. Removes power immediately on slot removal or loss of the main rail.

## Interface
- NUM_SLOTS, 4, number of slots; 2..8
- STAGGER_MS, 100, clk_1k cycles each granted slot holds the sequencer; 1..1023
- clk_1k  in  1  1 kHz system clock
- cpld_rst_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- prsnt_db  in  NUM_SLOTS  debounced presence, 1 = card present
- sys_pwr_ok  in  1  main 12 V rail good, level
- slot_pg  in  NUM_SLOTS  per-slot power-good; used only with SLOT_PG_CHECK_EN
- fault_clr  in  1  clears all slot_fault bits, level-sampled
- slot_pwr_en  out  NUM_SLOTS  per-slot power enable, registered
- slot_fault  out  NUM_SLOTS  sticky per-slot fault, registered
- seq_busy  out  1  1 while the FSM is not IDLE, registered

## Operation
- Reset on a clk_1k edge with cpld_rst_n=0:
  - slot_pwr_en=0, slot_fault=0, seq_busy=0
  - state=IDLE, cnt=0, rr_ptr=NUM_SLOTS-1
- Request vector: req = prsnt_db & ~slot_pwr_en & ~slot_fault & {NUM_SLOTS{sys_pwr_ok}}. It is combinational on the current inputs.
- Arbitration: the first set bit of req, searching from rr_ptr+1 upward modulo NUM_SLOTS.
- FSM states:
  - IDLE: if req≠0, grant index g. Set slot_pwr_en[g]=1, rr_ptr=g, cur=g, cnt=0, and go to STAGGER.
  - STAGGER: if cnt==STAGGER_MS-1, go to IDLE; otherwise cnt++.
- Removal: prsnt_db[i]=0 clears slot_pwr_en[i] and slot_fault[i] on the next edge, in any state. The FSM does not abort the stagger window.
- Rail loss: sys_pwr_ok=0 has priority over everything except reset. On the next edge:
  - slot_pwr_en=0
  - state=IDLE, cnt=0
  - slot_fault and rr_ptr are unchanged
- fault_clr=1 clears all slot_fault bits. If a new fault is set in the same cycle, the new fault wins for that bit.
- Grants never go to a slot whose presence or rail is low in the grant cycle.

## Timing
- Grant to enable: slot_pwr_en[g] rises on the same edge that IDLE samples req≠0 (1 cycle after the req inputs become valid).
- seq_busy rises on that same edge and falls on the edge where STAGGER exits.
- With requests continuously pending, successive enables are exactly STAGGER_MS+1 cycles apart.
- Removal to enable low: 1 edge.
- Rail loss to all enables low: 1 edge.
- rr_ptr wraps from NUM_SLOTS-1 to 0.
- Reset mid-STAGGER drops all enables on that edge. Re-sequencing restarts from slot 0.

## Configuration
- SLOT_PG_CHECK_EN defined:
  - At the STAGGER exit edge, if slot_pg[cur]=0 and slot_pwr_en[cur]=1: set slot_fault[cur]=1 and clear slot_pwr_en[cur].
  - Any enabled slot other than cur in STAGGER, with slot_pg=0, sets its fault and clears its enable on the next edge.
  - A faulted slot is excluded from req until its fault is cleared.
- SLOT_PG_CHECK_EN undefined:
  - slot_pg is ignored.
  - slot_fault is constant 0.

## Test plan
- Reset release with prsnt_db=4'b1011, sys_pwr_ok=1 (NUM_SLOTS=4, STAGGER_MS=100) -> slot_pwr_en goes 0001, 0011, 1011 on edges 1, 102 and 203 after release.
- Slot 1 removed mid-STAGGER of slot 3 -> slot_pwr_en[1]=0 on the next edge. seq_busy stays 1 until the window ends. Slot 1 is re-granted only after it reappears and a later IDLE.
- sys_pwr_ok drops with all enables on -> slot_pwr_en=0000 and seq_busy=0 on the next edge. Rail return resumes granting from rr_ptr+1.
- Round-robin: rr_ptr=2, req=4'b1001 -> slot 3 granted first, then slot 0 (wrap).
- SLOT_PG_CHECK_EN, slot_pg[0] held 0 -> at the STAGGER exit edge, slot_fault[0]=1 and slot_pwr_en[0]=0; no re-grant.
  - fault_clr pulse -> slot_fault[0]=0; re-granted at the next IDLE.
- SLOT_PG_CHECK_EN, slot 2 enabled and idle, slot_pg[2] falls -> on the next edge slot_fault[2]=1 and slot_pwr_en[2]=0. fault_clr in the same cycle leaves slot_fault[2]=1.
